// File: rtl/async_fifo_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// async_fifo_param
//
// Dual-clock FIFO moving DATA_WIDTH-bit words from the wclk domain to the rclk
// domain. Pointers are ADDR_WIDTH+1 bits wide, so the depth is 2**ADDR_WIDTH.
// Each pointer crosses as a registered Gray code through a SYNC_STAGES-deep
// flop chain and is converted back to binary on the far side. Flags and counts
// are computed from the stale (synchronised) view of the other pointer, so they
// can only err in the safe direction.
//
// Optional feature: define ASYNC_FIFO_FWFT_EN for first-word-fall-through.
// A prefetch register then presents the head word while empty=0, and rd_en
// pops it. Without the macro, rdata is loaded 1 rclk after an accepted rd_en.
//
// Ports
//   wclk, rclk    write / read clocks (unrelated)
//   reset         synchronous active-high, sampled separately in each domain
//   wr_en, wdata  write request and data (wclk)
//   full, almost_full, wr_count, overflow      write-side status (wclk)
//   rd_en         read / pop request (rclk)
//   rdata, empty, almost_empty, rd_count, underflow   read-side status (rclk)
//
// Parameters: DATA_WIDTH, ADDR_WIDTH (>= 2), SYNC_STAGES (2..4),
//   AFULL_THRESH (1..DEPTH), AEMPTY_THRESH (0..DEPTH-1).
// -----------------------------------------------------------------------------
module async_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  wclk,
    input  logic                  reset,
    input  logic                  rclk,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] AFULL_T   = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_T  = PW'(AEMPTY_THRESH);
    // Full in Gray space: the write pointer has lapped the read pointer once,
    // which shows up as the two MSBs inverted and the rest equal.
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(ADDR_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain state ----------------
    logic [PW-1:0] wptr_reg, wgray_reg, wr_count_reg;
    logic          full_reg, almost_full_reg, overflow_reg;
    logic [PW-1:0] r2w_sync_reg [SYNC_STAGES];

    // ---------------- read domain state -----------------
    logic [PW-1:0]         rptr_reg, rgray_reg, rd_count_reg;
    logic                  empty_reg, almost_empty_reg, underflow_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [PW-1:0]         w2r_sync_reg [SYNC_STAGES];

    // ---------------- crossing views --------------------
    logic [PW-1:0] rgray_sync, wgray_sync, rbin_sync, wbin_sync;

    assign rgray_sync = r2w_sync_reg[SYNC_STAGES-1];
    assign wgray_sync = w2r_sync_reg[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits from i upward.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign rbin_sync[gi] = ^rgray_sync[PW-1:gi];
            assign wbin_sync[gi] = ^wgray_sync[PW-1:gi];
        end
    endgenerate

    // ---------------- synchronisers ---------------------
    always_ff @(posedge wclk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r2w_sync_reg[i] <= '0;
            end
        end else begin
            r2w_sync_reg[0] <= rgray_reg;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r2w_sync_reg[i] <= r2w_sync_reg[i-1];
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                w2r_sync_reg[i] <= '0;
            end
        end else begin
            w2r_sync_reg[0] <= wgray_reg;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                w2r_sync_reg[i] <= w2r_sync_reg[i-1];
            end
        end
    end

    // ---------------- write side ------------------------
    logic          w_accept;
    logic [PW-1:0] wptr_next, wgray_next, wr_count_next;

    always_comb begin
        w_accept      = wr_en && !full_reg && !reset;
        wptr_next     = wptr_reg + PW'(w_accept);
        wgray_next    = wptr_next ^ (wptr_next >> 1);
        wr_count_next = wptr_next - rbin_sync;
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            wptr_reg        <= '0;
            wgray_reg       <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= (AFULL_THRESH == 0);
            wr_count_reg    <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            wptr_reg        <= wptr_next;
            wgray_reg       <= wgray_next;
            full_reg        <= (wgray_next == (rgray_sync ^ FULL_MASK));
            wr_count_reg    <= wr_count_next;
            almost_full_reg <= (wr_count_next >= AFULL_T);
            overflow_reg    <= wr_en && full_reg;
        end
    end

    // Memory is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge wclk) begin
        if (w_accept) begin
            mem[wptr_reg[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    // ---------------- read side -------------------------
    // rptr_reg always counts words handed to the consumer; in FWFT mode the
    // word sitting in the prefetch register is therefore still counted as
    // occupied on both sides until it is popped.
    logic          r_accept;
    logic [PW-1:0] rptr_next, rgray_next, rd_count_next;

    always_comb begin
        r_accept      = rd_en && !empty_reg;
        rptr_next     = rptr_reg + PW'(r_accept);
        rgray_next    = rptr_next ^ (rptr_next >> 1);
        rd_count_next = wbin_sync - rptr_next;
    end

`ifdef ASYNC_FIFO_FWFT_EN
    // The next head word lives at rptr_next; it is fetchable once the
    // synchronised write pointer has moved past it.
    logic head_avail, head_load;

    always_comb begin
        head_avail = (rptr_next != wbin_sync);
        head_load  = (empty_reg || r_accept) && head_avail;
    end
`endif

    always_ff @(posedge rclk) begin
        if (reset) begin
            rptr_reg         <= '0;
            rgray_reg        <= '0;
            empty_reg        <= 1'b1;
            almost_empty_reg <= 1'b1;
            rd_count_reg     <= '0;
            underflow_reg    <= 1'b0;
            rdata_reg        <= '0;
        end else begin
            rptr_reg         <= rptr_next;
            rgray_reg        <= rgray_next;
            rd_count_reg     <= rd_count_next;
            almost_empty_reg <= (rd_count_next <= AEMPTY_T);
            underflow_reg    <= rd_en && empty_reg;
`ifdef ASYNC_FIFO_FWFT_EN
            // Only re-evaluate the prefetch slot when it is free or being
            // popped; rdata holds its last word when nothing new is available.
            if (empty_reg || r_accept) begin
                empty_reg <= !head_avail;
            end
            if (head_load) begin
                rdata_reg <= mem[rptr_next[ADDR_WIDTH-1:0]];
            end
`else
            empty_reg <= (rgray_next == wgray_sync);
            if (r_accept) begin
                rdata_reg <= mem[rptr_reg[ADDR_WIDTH-1:0]];
            end
`endif
        end
    end

    // ---------------- outputs ---------------------------
    assign full         = full_reg;
    assign almost_full  = almost_full_reg;
    assign wr_count     = wr_count_reg;
    assign overflow     = overflow_reg;
    assign rdata        = rdata_reg;
    assign empty        = empty_reg;
    assign almost_empty = almost_empty_reg;
    assign rd_count     = rd_count_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_async_fifo_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_async_fifo_param
//
// Directed bench for async_fifo_param at default parameters: reset state,
// fill to full with overflow, drain with underflow, empty-deassert latency,
// two random-traffic scoreboard runs at swapped clock ratios, and a reset
// with data stored. Works in both standard and FWFT builds.
// -----------------------------------------------------------------------------
module tb_async_fifo_param;

    localparam int DW = 8;
    localparam int AW = 4;
`ifdef ASYNC_FIFO_FWFT_EN
    localparam int LAT_LIM = 5;
`else
    localparam int LAT_LIM = 4;
`endif

    logic          wclk  = 1'b0;
    logic          rclk  = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          full, almost_full, overflow;
    logic          empty, almost_empty, underflow;
    logic [AW:0]   wr_count, rd_count;
    logic [DW-1:0] rdata;

    realtime wh = 5.0;
    realtime rh = 8.5;

    int            tests  = 0;
    int            fails  = 0;
    int            wcount = 0;
    int            rcount = 0;
    logic [DW-1:0] sb_q[$];

    async_fifo_param dut (
        .wclk         (wclk),
        .reset        (reset),
        .rclk         (rclk),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .full         (full),
        .almost_full  (almost_full),
        .wr_count     (wr_count),
        .overflow     (overflow),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow)
    );

    initial forever #(wh) wclk = ~wclk;
    initial forever #(rh) rclk = ~rclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [DW-1:0] d, output logic ovf);
        @(negedge wclk);
        wr_en = 1'b1;
        wdata = d;
        @(posedge wclk);
        #1;
        wr_en = 1'b0;
        ovf   = overflow;
        $display("[TB] wr 0x%02h full=%0b almost_full=%0b wr_count=%0d overflow=%0b",
                 d, full, almost_full, wr_count, ovf);
    endtask

    // Returns the word delivered by this read: the registered result in
    // standard mode, the presented head word in FWFT mode.
    task automatic do_read(output logic [DW-1:0] d, output logic uf);
        @(negedge rclk);
`ifdef ASYNC_FIFO_FWFT_EN
        d = rdata;
`endif
        rd_en = 1'b1;
        @(posedge rclk);
        #1;
        rd_en = 1'b0;
`ifndef ASYNC_FIFO_FWFT_EN
        d = rdata;
`endif
        uf = underflow;
        $display("[TB] rd 0x%02h empty=%0b almost_empty=%0b rd_count=%0d underflow=%0b",
                 d, empty, almost_empty, rd_count, uf);
    endtask

    task automatic do_reset();
        @(negedge wclk);
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (3) @(posedge rclk);
        // Requests while in reset must be ignored and raise no pulses.
        @(negedge wclk);
        wr_en = 1'b1;
        wdata = 8'hEE;
        @(negedge rclk);
        rd_en = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        check_eq("rst_no_overflow", overflow, 0);
        check_eq("rst_no_underflow", underflow, 0);
        @(negedge wclk);
        wr_en = 1'b0;
        @(negedge rclk);
        rd_en = 1'b0;
        repeat (3) @(posedge rclk);
        repeat (6) @(posedge wclk);
        @(negedge rclk);
        reset = 1'b0;
        #1;
        $display("[TB] reset released at %0t", $time);
    endtask

    task automatic wait_rd_count(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge rclk);
            #1;
            if (int'(rd_count) == target) ok = 1'b1;
        end
    endtask

    task automatic run_random(input int n, input string name);
        fork
            begin : wr_proc
                int sent;
                int cyc;
                bit acc;
                sent = 0;
                cyc  = 0;
                while (sent < n && cyc < 8 * n) begin
                    @(negedge wclk);
                    cyc++;
                    check_eq("wr_count_pessimistic", (int'(wr_count) >= (wcount - rcount)), 1);
                    wr_en = ($urandom_range(0, 1) == 1);
                    wdata = 8'(sent * 7 + 3);
                    acc   = wr_en && !full;
                    @(posedge wclk);
                    if (acc) begin
                        sb_q.push_back(wdata);
                        wcount++;
                        sent++;
                    end
                end
                @(negedge wclk);
                wr_en = 1'b0;
                check_eq("rand_sent", sent, n);
            end
            begin : rd_proc
                int            got;
                int            cyc;
                bit            acc;
                logic [DW-1:0] exp;
                got = 0;
                cyc = 0;
                while (got < n && cyc < 8 * n) begin
                    @(negedge rclk);
                    cyc++;
                    check_eq("rd_count_pessimistic", (int'(rd_count) <= (wcount - rcount)), 1);
                    rd_en = ($urandom_range(0, 1) == 1);
                    acc   = rd_en && !empty;
`ifdef ASYNC_FIFO_FWFT_EN
                    if (acc) begin
                        check_eq("sb_nonempty", (sb_q.size() > 0), 1);
                        if (sb_q.size() > 0) check_eq("sb_data", rdata, sb_q[0]);
                    end
                    @(posedge rclk);
                    if (acc) begin
                        if (sb_q.size() > 0) void'(sb_q.pop_front());
                        rcount++;
                        got++;
                    end
`else
                    @(posedge rclk);
                    if (acc) rcount++;
                    #1;
                    if (acc) begin
                        check_eq("sb_nonempty", (sb_q.size() > 0), 1);
                        if (sb_q.size() > 0) begin
                            exp = sb_q.pop_front();
                            check_eq("sb_data", rdata, exp);
                        end
                        got++;
                    end
`endif
                end
                @(negedge rclk);
                rd_en = 1'b0;
                check_eq("rand_received", got, n);
            end
        join
        check_eq("sb_left_over", sb_q.size(), 0);
        $display("[TB] random run %s: %0d words, written=%0d read=%0d", name, n, wcount, rcount);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          f;
        bit            ok;
        int            n_edges;

        // ---- reset state ----
        do_reset();
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_almost_empty", almost_empty, 1);
        check_eq("rst_almost_full", almost_full, 0);
        check_eq("rst_wr_count", wr_count, 0);
        check_eq("rst_rd_count", rd_count, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_underflow", underflow, 0);

        // ---- fill 0x01..0x10 ----
        for (int i = 1; i <= 16; i++) begin
            do_write(8'(i), f);
            check_eq("fill_wr_count", wr_count, i);
            check_eq("fill_almost_full", almost_full, (i >= 14));
            check_eq("fill_full", full, (i == 16));
            check_eq("fill_overflow", f, 0);
        end
        do_write(8'hAA, f);
        check_eq("ovf_pulse", f, 1);
        check_eq("ovf_wr_count", wr_count, 16);
        check_eq("ovf_full", full, 1);
        @(posedge wclk);
        #1;
        check_eq("ovf_pulse_end", overflow, 0);

        wait_rd_count(16, 20, ok);
        check_eq("rd_count_16_timeout", ok, 1);
        check_eq("filled_empty", empty, 0);
        check_eq("filled_almost_empty", almost_empty, 0);

        // ---- drain ----
        for (int i = 1; i <= 16; i++) begin
            do_read(d, f);
            check_eq("drain_data", d, i);
            check_eq("drain_underflow", f, 0);
        end
        do_read(d, f);
        check_eq("udf_pulse", f, 1);
        check_eq("udf_rdata_hold", rdata, 8'h10);
        check_eq("udf_empty", empty, 1);
        check_eq("udf_rd_count", rd_count, 0);
        check_eq("udf_almost_empty", almost_empty, 1);

        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(posedge wclk);
            #1;
            if (!full && wr_count == 0) ok = 1'b1;
        end
        check_eq("full_clear_timeout", ok, 1);

        // ---- empty-deassert latency ----
        @(negedge wclk);
        wr_en = 1'b1;
        wdata = 8'h5C;
        @(posedge wclk);
        fork
            begin
                #1;
                wr_en = 1'b0;
            end
        join_none
        n_edges = 0;
        ok      = 1'b0;
        while (n_edges < 8 && !ok) begin
            @(posedge rclk);
            n_edges++;
            #1;
            if (!empty) ok = 1'b1;
        end
        $display("[TB] wr 0x5c into empty fifo, empty dropped after %0d rclk edges", n_edges);
        check_eq("empty_latency", (ok && n_edges <= LAT_LIM), 1);
`ifdef ASYNC_FIFO_FWFT_EN
        check_eq("fwft_head_early", rdata, 8'h5C);
`endif
        do_read(d, f);
        check_eq("single_data", d, 8'h5C);
        check_eq("single_underflow", f, 0);

        // ---- random traffic, both clock ratios ----
        repeat (4) @(posedge rclk);
        run_random(3000, "w10_r17");
        wh = 8.5;
        rh = 5.0;
        repeat (4) @(posedge wclk);
        run_random(3000, "w17_r10");
        wh = 5.0;
        rh = 8.5;
        repeat (4) @(posedge wclk);

        // ---- reset with 9 words stored ----
        for (int i = 0; i < 9; i++) begin
            do_write(8'(8'h30 + i), f);
        end
        wait_rd_count(9, 20, ok);
        check_eq("rd_count_9_timeout", ok, 1);
        do_reset();
        check_eq("midrst_empty", empty, 1);
        check_eq("midrst_rd_count", rd_count, 0);
        check_eq("midrst_wr_count", wr_count, 0);
        check_eq("midrst_full", full, 0);
        check_eq("midrst_almost_empty", almost_empty, 1);
        do_write(8'h77, f);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge rclk);
            #1;
            if (!empty) ok = 1'b1;
        end
        check_eq("midrst_empty_timeout", ok, 1);
        do_read(d, f);
        check_eq("midrst_first_word", d, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
